// File: rtl/comperator_axi_ip_v1_0_block_scheduler.sv
// Frame-level sequencer for the stereo block readers and the block comparator:
// walks every block of the frame, issuing reader go pulses and comparator starts in turn.
module comperator_axi_ip_v1_0_block_scheduler #(
  parameter int unsigned BLOCKS_PER_ROW = 80,
  parameter int unsigned BLOCK_ROWS     = 480,
  parameter int unsigned TIMEOUT        = 65535
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic        abort,
  output logic        go_left,
  output logic        go_right,
  input  logic        done_left,
  input  logic        done_right,
  output logic        cmp_start,
  input  logic        cmp_done,
  output logic [15:0] block_col,
  output logic [15:0] block_row,
  output logic        busy,
  output logic        frame_done,
  output logic        error
);

  localparam logic [15:0] LAST_COL = 16'(BLOCKS_PER_ROW - 1);
  localparam logic [15:0] LAST_ROW = 16'(BLOCK_ROWS - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_ARM      = 3'd2,
    S_WAIT_RD  = 3'd3,
    S_CMP      = 3'd4,
    S_WAIT_CMP = 3'd5,
    S_ADVANCE  = 3'd6
  } state_t;

  state_t      state_q;
  logic [15:0] col_q, row_q, timer_q;
  logic        got_l_q, got_r_q;
  logic        go_q, cmp_start_q, busy_q, frame_done_q, error_q;
  logic        got_l_d, got_r_d;

  // Reader dones are sticky within a block so they may arrive in any order.
  assign got_l_d = got_l_q | done_left;
  assign got_r_d = got_r_q | done_right;

  // Sequencer state, position counters, wait timer and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      col_q        <= 16'd0;
      row_q        <= 16'd0;
      timer_q      <= 16'd0;
      got_l_q      <= 1'b0;
      got_r_q      <= 1'b0;
      go_q         <= 1'b0;
      cmp_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      go_q         <= 1'b0;
      cmp_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        col_q   <= 16'd0;
        row_q   <= 16'd0;
        timer_q <= 16'd0;
        got_l_q <= 1'b0;
        got_r_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_ISSUE;
              col_q   <= 16'd0;
              row_q   <= 16'd0;
              error_q <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              busy_q  <= 1'b0;
            end
          end
          S_ISSUE: begin
            go_q    <= 1'b1;
            got_l_q <= 1'b0;
            got_r_q <= 1'b0;
            state_q <= S_ARM;
          end
          // Readers still show the previous done for one cycle after go.
          S_ARM: begin
            timer_q <= 16'd0;
            state_q <= S_WAIT_RD;
          end
          S_WAIT_RD: begin
            got_l_q <= got_l_d;
            got_r_q <= got_r_d;
            if (got_l_d && got_r_d) begin
              state_q <= S_CMP;
            end else if (timer_q == TMO_LAST) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              timer_q <= timer_q + 16'd1;
            end
          end
          S_CMP: begin
            cmp_start_q <= 1'b1;
            timer_q     <= 16'd0;
            state_q     <= S_WAIT_CMP;
          end
          S_WAIT_CMP: begin
            if (cmp_done) begin
              state_q <= S_ADVANCE;
            end else if (timer_q == TMO_LAST) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              timer_q <= timer_q + 16'd1;
            end
          end
          S_ADVANCE: begin
            if (col_q == LAST_COL) begin
              if (row_q == LAST_ROW) begin
                frame_done_q <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= S_IDLE;
              end else begin
                col_q   <= 16'd0;
                row_q   <= row_q + 16'd1;
                state_q <= S_ISSUE;
              end
            end else begin
              col_q   <= col_q + 16'd1;
              state_q <= S_ISSUE;
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign go_left    = go_q;
  assign go_right   = go_q;
  assign cmp_start  = cmp_start_q;
  assign block_col  = col_q;
  assign block_row  = row_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_comperator_axi_ip_v1_0_block_scheduler.sv
// Bench for the block scheduler: a 3x2 instance (TIMEOUT=16) driven by a reader/comparator
// model with random latencies, plus a 1x1 instance for the single-block frame.
module tb_comperator_axi_ip_v1_0_block_scheduler;

  logic aclk = 1'b0;
  logic aresetn, start, abort, done_left, done_right, cmp_done;
  logic d_go_l, d_go_r, d_cs, d_busy, d_fd, d_err;
  logic [15:0] d_col, d_row;
  logic e_go_l, e_go_r, e_cs, e_busy, e_fd, e_err;
  logic [15:0] e_col, e_row;

  int n_err = 0;
  int n_chk = 0;
  int lat_l_a[6];
  int lat_r_a[6];
  int lat_c_a[6];
  bit spur_en;

  comperator_axi_ip_v1_0_block_scheduler #(
    .BLOCKS_PER_ROW(3), .BLOCK_ROWS(2), .TIMEOUT(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .go_left(d_go_l), .go_right(d_go_r), .done_left(done_left), .done_right(done_right),
    .cmp_start(d_cs), .cmp_done(cmp_done), .block_col(d_col), .block_row(d_row),
    .busy(d_busy), .frame_done(d_fd), .error(d_err)
  );

  comperator_axi_ip_v1_0_block_scheduler #(
    .BLOCKS_PER_ROW(1), .BLOCK_ROWS(1), .TIMEOUT(16)
  ) dut1 (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .go_left(e_go_l), .go_right(e_go_r), .done_left(done_left), .done_right(done_right),
    .cmp_start(e_cs), .cmp_done(cmp_done), .block_col(e_col), .block_row(e_row),
    .busy(e_busy), .frame_done(e_fd), .error(e_err)
  );

  always #5 aclk = ~aclk;

  task automatic test_reset();
    aresetn = 1'b0; start = 1'b0; abort = 1'b0;
    done_left = 1'b0; done_right = 1'b0; cmp_done = 1'b0;
    repeat (2) @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    n_chk++;
    if ({d_go_l, d_go_r, d_cs, d_busy, d_fd, d_err, d_col, d_row} !== 38'd0) begin
      n_err++; $display("FAIL reset_dut: got %h want 0", {d_go_l, d_go_r, d_cs, d_busy, d_fd, d_err, d_col, d_row});
    end
    n_chk++;
    if ({e_go_l, e_go_r, e_cs, e_busy, e_fd, e_err, e_col, e_row} !== 38'd0) begin
      n_err++; $display("FAIL reset_dut1: got %h want 0", {e_go_l, e_go_r, e_cs, e_busy, e_fd, e_err, e_col, e_row});
    end
    aresetn = 1'b1;
    @(negedge aclk);
    n_chk++;
    if (d_busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b want 0", d_busy); end
  endtask

  // Single-block frame: dones at +5, cmp_done 3 cycles after cmp_start.
  task automatic test_one_block();
    bit w;
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0; start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge aclk);
      start = 1'b0;
      w = (k == 1);
      n_chk++;
      if (e_go_l !== w || e_go_r !== w) begin n_err++; $display("FAIL one_go k=%0d: got %b%b want %b", k, e_go_l, e_go_r, w); end
      w = (k == 7);
      n_chk++;
      if (e_cs !== w) begin n_err++; $display("FAIL one_cmp_start k=%0d: got %b want %b", k, e_cs, w); end
      w = (k == 12);
      n_chk++;
      if (e_fd !== w) begin n_err++; $display("FAIL one_frame_done k=%0d: got %b want %b", k, e_fd, w); end
      w = (k < 12);
      n_chk++;
      if (e_busy !== w) begin n_err++; $display("FAIL one_busy k=%0d: got %b want %b", k, e_busy, w); end
      done_left  = (k >= 5 && k < 12);
      done_right = (k >= 5 && k < 12);
      cmp_done   = (k == 10);
    end
    done_left = 1'b0; done_right = 1'b0; cmp_done = 1'b0;
  endtask

  // Full 3x2 frame using per-block latencies in lat_*_a; readers drop done the cycle after go.
  task automatic run_frame(input string tag);
    int g, tl, tr, c, ecs, ego, efd, blk, kend;
    bit w, spur;
    g = -100; tl = 1000; tr = 1000; c = -1; ecs = -1; ego = 1; efd = -1; blk = 0; kend = -1;
    cmp_done = 1'b0; abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0; start = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge aclk);
      start = 1'b0;
      kend = k;
      w = (k == ego);
      n_chk++;
      if (d_go_l !== w || d_go_r !== w) begin n_err++; $display("FAIL %s go k=%0d: got %b%b want %b", tag, k, d_go_l, d_go_r, w); end
      w = (k == ecs);
      n_chk++;
      if (d_cs !== w) begin n_err++; $display("FAIL %s cmp_start k=%0d: got %b want %b", tag, k, d_cs, w); end
      w = (k == efd);
      n_chk++;
      if (d_fd !== w) begin n_err++; $display("FAIL %s frame_done k=%0d: got %b want %b", tag, k, d_fd, w); end
      w = (efd < 0 || k < efd);
      n_chk++;
      if (d_busy !== w) begin n_err++; $display("FAIL %s busy k=%0d: got %b want %b", tag, k, d_busy, w); end
      if (efd >= 0 && k == efd + 3) break;
      if (k == ego) begin
        g  = k;
        tl = g + 1 + lat_l_a[blk];
        tr = g + 1 + lat_r_a[blk];
        ecs = ((tl > tr) ? tl : tr) + 2;
      end
      if (k == ecs) begin
        n_chk++;
        if (d_col !== 16'(blk % 3) || d_row !== 16'(blk / 3)) begin
          n_err++; $display("FAIL %s coord blk=%0d: got (%0d,%0d) want (%0d,%0d)", tag, blk, d_col, d_row, blk % 3, blk / 3);
        end
        n_chk++;
        if (!(done_left && done_right)) begin
          n_err++; $display("FAIL %s cmp_before_dones blk=%0d: got %b%b want 11", tag, blk, done_left, done_right);
        end
        c = k + lat_c_a[blk];
        if (blk == 5) efd = c + 2;
        else ego = c + 3;
        blk++;
      end
      if (k == g + 1) begin done_left = 1'b0; done_right = 1'b0; end
      if (k == tl) done_left = 1'b1;
      if (k == tr) done_right = 1'b1;
      spur = spur_en && ($urandom_range(7, 0) == 0) && !(k >= ecs && k <= c);
      cmp_done = (k == c) || spur;
    end
    n_chk++;
    if (efd < 0 || blk != 6 || kend != efd + 3) begin
      n_err++; $display("FAIL %s complete: got blocks=%0d end=%0d want blocks=6 end=%0d", tag, blk, kend, efd + 3);
    end
    n_chk++;
    if (d_col !== 16'd2 || d_row !== 16'd1) begin
      n_err++; $display("FAIL %s final_coord: got (%0d,%0d) want (2,1)", tag, d_col, d_row);
    end
    done_left = 1'b0; done_right = 1'b0; cmp_done = 1'b0;
  endtask

  task automatic randomize_lat();
    for (int i = 0; i < 6; i++) begin
      lat_l_a[i] = int'($urandom_range(12, 0));
      lat_r_a[i] = int'($urandom_range(12, 0));
      lat_c_a[i] = int'($urandom_range(10, 0));
    end
  endtask

  task automatic test_full_frame();
    for (int r = 0; r < 3; r++) begin
      randomize_lat();
      spur_en = 1'b1;
      run_frame("frame");
    end
  endtask

  task automatic test_done_order();
    randomize_lat();
    lat_r_a[0] = 0; lat_l_a[0] = 10;
    lat_r_a[1] = 4; lat_l_a[1] = 4;
    spur_en = 1'b0;
    run_frame("order");
  endtask

  task automatic test_stale_done();
    randomize_lat();
    for (int i = 0; i < 6; i++) begin lat_l_a[i] = 6; lat_r_a[i] = 6; end
    spur_en = 1'b0;
    done_left = 1'b1; done_right = 1'b1;
    run_frame("stale");
  endtask

  task automatic test_timeout();
    bit w;
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0; done_left = 1'b0; done_right = 1'b0; start = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(negedge aclk);
      start = 1'b0;
      w = (k >= 18);
      n_chk++;
      if (d_err !== w) begin n_err++; $display("FAIL tmo_error k=%0d: got %b want %b", k, d_err, w); end
      n_chk++;
      if (d_busy !== !w) begin n_err++; $display("FAIL tmo_busy k=%0d: got %b want %b", k, d_busy, !w); end
      n_chk++;
      if (d_cs !== 1'b0 || d_fd !== 1'b0) begin n_err++; $display("FAIL tmo_pulses k=%0d: got %b%b want 00", k, d_cs, d_fd); end
      done_right = (k >= 3);
    end
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
    n_chk++;
    if (d_err !== 1'b1 || d_busy !== 1'b0) begin n_err++; $display("FAIL tmo_abort_keeps_error: got err=%b busy=%b want 1/0", d_err, d_busy); end
    start = 1'b1; abort = 1'b1;
    @(negedge aclk);
    start = 1'b0; abort = 1'b0;
    n_chk++;
    if (d_err !== 1'b1 || d_busy !== 1'b0) begin n_err++; $display("FAIL start_abort_same: got err=%b busy=%b want 1/0", d_err, d_busy); end
    done_right = 1'b0; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    n_chk++;
    if (d_err !== 1'b0 || d_busy !== 1'b1) begin n_err++; $display("FAIL start_clears_error: got err=%b busy=%b want 0/1", d_err, d_busy); end
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
  endtask

  // Runs block (0,0) to completion and stops in the negedge where block (1,0) shows cmp_start.
  task automatic reach_second_cmp(input string tag);
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0; done_left = 1'b0; done_right = 1'b0; cmp_done = 1'b0; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge aclk);
      start = 1'b0;
      if (k < 11) begin
        done_left  = (k >= 2 && k < 8) || k >= 9;
        done_right = done_left;
        cmp_done   = (k == 4);
      end
    end
    n_chk++;
    if (d_cs !== 1'b1 || d_col !== 16'd1 || d_row !== 16'd0) begin
      n_err++; $display("FAIL %s setup: got cs=%b col=%0d row=%0d want 1,1,0", tag, d_cs, d_col, d_row);
    end
  endtask

  task automatic test_abort();
    reach_second_cmp("abort");
    cmp_done = 1'b1; abort = 1'b1;
    @(negedge aclk);
    cmp_done = 1'b0; abort = 1'b0; done_left = 1'b0; done_right = 1'b0;
    n_chk++;
    if (d_busy !== 1'b0 || d_col !== 16'd0 || d_row !== 16'd0 || d_cs !== 1'b0) begin
      n_err++; $display("FAIL abort_idle: got busy=%b col=%0d row=%0d cs=%b want 0,0,0,0", d_busy, d_col, d_row, d_cs);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      n_chk++;
      if (d_go_l !== 1'b0 || d_fd !== 1'b0 || d_busy !== 1'b0 || d_col !== 16'd0) begin
        n_err++; $display("FAIL abort_quiet k=%0d: got go=%b fd=%b busy=%b col=%0d want 0", k, d_go_l, d_fd, d_busy, d_col);
      end
    end
  endtask

  task automatic test_async_reset();
    reach_second_cmp("areset");
    #2 aresetn = 1'b0;
    #1;
    n_chk++;
    if ({d_go_l, d_go_r, d_cs, d_busy, d_fd, d_err, d_col, d_row} !== 38'd0) begin
      n_err++; $display("FAIL async_reset: got %h want 0", {d_go_l, d_go_r, d_cs, d_busy, d_fd, d_err, d_col, d_row});
    end
    done_left = 1'b0; done_right = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    n_chk++;
    if (d_busy !== 1'b0 || d_go_l !== 1'b0) begin n_err++; $display("FAIL async_release: got busy=%b go=%b want 0/0", d_busy, d_go_l); end
  endtask

  initial begin
    test_reset();
    test_one_block();
    test_full_frame();
    test_done_order();
    test_stale_done();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
